reg_dump: RTL

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump -- walks a register file through one combinational read port and
// streams every register out as a valid/ready beat (index + value).
//
// A start pulse in IDLE launches a dump. Each register costs one LOAD cycle,
// where the read port settles and the value is snapshotted, plus at least one
// SEND cycle, where the beat is offered until the consumer takes it. After the
// last register is accepted, DONE pulses for one cycle. abort cancels a dump
// from any non-idle state.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   begin a dump (only looked at in IDLE)
//   abort     in   cancel a dump in progress; also blocks a coincident start
//   rf_addr   out  register-file read address (always the current index)
//   rf_data   in   combinational read data for rf_addr
//   tx_valid  out  beat present on tx_addr/tx_data
//   tx_ready  in   consumer accepts the beat
//   tx_addr   out  index of the register in the current beat
//   tx_data   out  value sampled from that register
//   busy      out  high whenever the block is not idle
//   done      out  one-cycle pulse after the final beat is accepted
//
// Configuration
//   REG_DUMP_SKIP_X0_EN  when defined, register 0 is skipped and the dump
//                        starts at index 1 (one beat fewer).
// -----------------------------------------------------------------------------
module reg_dump #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   output logic [ADDRESS_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0]    rf_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [ADDRESS_WIDTH-1:0] tx_addr,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef REG_DUMP_SKIP_X0_EN
   localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);
`else
   localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = '0;
`endif
   // The index never wraps: reaching the all-ones index ends the dump.
   localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = '1;

   logic [1:0]               state_reg;
   logic [ADDRESS_WIDTH-1:0] idx_reg;
   logic                     valid_reg;
   logic [ADDRESS_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0]    data_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else if (abort) begin
         // abort outranks everything, including a beat being handshaken in
         // this same cycle (that beat is treated as never transferred) and
         // a start arriving in IDLE.
         state_reg <= S_IDLE;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg <= S_LOAD;
                  idx_reg   <= FIRST_IDX;
               end
            end
            S_LOAD: begin
               // Snapshot: later register-file writes cannot touch this beat.
               data_reg  <= rf_data;
               addr_reg  <= idx_reg;
               valid_reg <= 1'b1;
               state_reg <= S_SEND;
            end
            S_SEND: begin
               if (valid_reg && tx_ready) begin
                  valid_reg <= 1'b0;
                  if (idx_reg == LAST_IDX) begin
                     state_reg <= S_DONE;
                  end else begin
                     idx_reg   <= idx_reg + ADDRESS_WIDTH'(1);
                     state_reg <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign rf_addr  = idx_reg;
   assign tx_valid = valid_reg;
   assign tx_addr  = addr_reg;
   assign tx_data  = data_reg;
   assign busy     = (state_reg != S_IDLE);
   assign done     = (state_reg == S_DONE);

endmodule
